// File: rtl/pe_start_sequencer_pkg.sv
// Shared types and defaults for the PE start sequencer.
// Holds the FSM state encoding and the default parameter values.
package pe_start_sequencer_pkg;

  localparam int DEF_DATA_WIDTH = 1;
  localparam int DEF_CNT_WIDTH  = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/pe_start_sequencer.sv
// Pops a start token, runs one PE iteration over ap_ctrl_hs,
// then forwards the token to the done FIFO and counts the iteration.
module pe_start_sequencer
  import pe_start_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  in_empty_n,
  output logic                  in_read,
  input  logic [DATA_WIDTH-1:0] in_dout,
  output logic                  pe_ap_start,
  input  logic                  pe_ap_ready,
  input  logic                  pe_ap_done,
  output logic                  pe_ap_continue,
  input  logic                  out_full_n,
  output logic                  out_write,
  output logic [DATA_WIDTH-1:0] out_din,
  output logic [CNT_WIDTH-1:0]  iter_count,
  output logic                  busy
);

  state_e                state;
  state_e                state_nxt;
  logic [DATA_WIDTH-1:0] token;
  logic                  take;
  logic                  give;

  // Handshake outputs are masked during reset so no FIFO moves.
  assign take = !ap_rst && (state == IDLE) && in_empty_n;
  assign give = !ap_rst && (state == DONE) && out_full_n;

  assign in_read        = take;
  assign pe_ap_start    = !ap_rst && (state == START);
  assign pe_ap_continue = give;
  assign out_write      = give;
  assign out_din        = token;
  assign busy           = (state != IDLE);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (in_empty_n) state_nxt = START;
      end
      START: begin
        if (pe_ap_ready)
          state_nxt = pe_ap_done ? DONE : RUN;
      end
      RUN: begin
        if (pe_ap_done) state_nxt = DONE;
      end
      DONE: begin
        if (out_full_n) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state      <= IDLE;
      token      <= '0;
      iter_count <= '0;
    end else begin
      state <= state_nxt;
      if (take) token <= in_dout;
      if (give) iter_count <= iter_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_pe_start_sequencer.sv
// Scoreboard bench for pe_start_sequencer: FIFO and PE models,
// expected tokens queued at push time, monitor checks each write.
module tb_pe_start_sequencer;

  logic       ap_clk = 1'b0;
  logic       ap_rst = 1'b1;
  logic       in_empty_n;
  logic [0:0] in_dout;
  logic       pe_ap_ready = 1'b0;
  logic       pe_ap_done  = 1'b0;
  logic       out_full_n  = 1'b1;

  logic        in_read, pe_ap_start, pe_ap_continue, out_write, busy;
  logic [0:0]  out_din;
  logic [31:0] iter_count;

  logic       w_in_read, w_pe_ap_start, w_pe_ap_continue, w_out_write;
  logic       w_busy;
  logic [0:0] w_out_din;
  logic [1:0] w_iter_count;

  logic [0:0] in_q[$];
  logic [0:0] exp_q[$];
  int         in_cnt = 0;
  logic [0:0] in_head = 1'b0;
  logic       in_force = 1'b1;

  int vectors = 0;
  int miscompares = 0;

  int rdy_dly = 0;
  int done_dly = 0;
  int pe_t = -1;
  bit spur_req = 1'b0;
  bit pe_done_seen = 1'b0;

  bit          gap_chk = 1'b0;
  int          cyc = 0;
  int          last_wr = -1;
  int          st_len = 0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  logic [31:0] exp_cnt = 0;

  assign in_empty_n = in_force | (in_cnt != 0);
  assign in_dout    = in_head;

  pe_start_sequencer dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .in_empty_n(in_empty_n), .in_read(in_read), .in_dout(in_dout),
    .pe_ap_start(pe_ap_start), .pe_ap_ready(pe_ap_ready),
    .pe_ap_done(pe_ap_done), .pe_ap_continue(pe_ap_continue),
    .out_full_n(out_full_n), .out_write(out_write), .out_din(out_din),
    .iter_count(iter_count), .busy(busy)
  );

  pe_start_sequencer #(.DATA_WIDTH(1), .CNT_WIDTH(2)) dut_w (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .in_empty_n(in_empty_n), .in_read(w_in_read), .in_dout(in_dout),
    .pe_ap_start(w_pe_ap_start), .pe_ap_ready(pe_ap_ready),
    .pe_ap_done(pe_ap_done), .pe_ap_continue(w_pe_ap_continue),
    .out_full_n(out_full_n), .out_write(w_out_write), .out_din(w_out_din),
    .iter_count(w_iter_count), .busy(w_busy)
  );

  always #5 ap_clk = ~ap_clk;

  function automatic void chk(string name, logic [31:0] act,
                              logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  task automatic tick();
    @(posedge ap_clk);
    #2;
  endtask

  task automatic push_in(input logic [0:0] t, input bit expect_out);
    in_q.push_back(t);
    in_cnt  = in_q.size();
    in_head = in_q[0];
    if (expect_out) exp_q.push_back(t);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || in_cnt != 0 || busy) && n < budget) begin
      tick();
      n++;
    end
    chk("drain_timeout", 32'(n >= budget), 0);
  endtask

  // Start-token FIFO and PE models.
  initial begin
    bit rd;
    forever begin
      @(negedge ap_clk);
      rd = in_read;
      @(posedge ap_clk);
      #1;
      if (rd && in_q.size() != 0) begin
        void'(in_q.pop_front());
        in_cnt  = in_q.size();
        in_head = (in_cnt != 0) ? in_q[0] : 1'b0;
      end
      pe_ap_ready = 1'b0;
      pe_ap_done  = spur_req;
      spur_req    = 1'b0;
      if (ap_rst) pe_t = -1;
      else if (pe_t < 0 && pe_ap_start) pe_t = 0;
      else if (pe_t >= 0) pe_t++;
      if (pe_t >= 0) begin
        if (pe_t == rdy_dly && pe_ap_start) pe_ap_ready = 1'b1;
        if (pe_t == done_dly) begin
          pe_ap_done   = 1'b1;
          pe_done_seen = 1'b1;
          pe_t         = -1;
        end
      end
    end
  end

  // Monitor: protocol rules every cycle, scoreboard on each write.
  initial begin
    logic [0:0] tok;
    forever begin
      @(negedge ap_clk);
      cyc++;
      if (ap_rst) begin
        chk("reset_outputs",
            32'({in_read, pe_ap_start, pe_ap_continue, out_write}), 0);
        st_len = 0;
      end else begin
        chk("protocol", 32'({in_read & out_write,
                             in_read & ~in_empty_n,
                             out_write & ~out_full_n,
                             out_write ^ pe_ap_continue,
                             out_write ^ w_out_write,
                             in_read ^ w_in_read}), 0);
        if (in_read) rd_cnt++;
        if (pe_ap_start) st_len++;
        else if (st_len != 0) begin
          chk("start_len", st_len, rdy_dly + 1);
          st_len = 0;
        end
        if (out_write) begin
          wr_cnt++;
          if (exp_q.size() == 0) begin
            chk("unexpected_write", 1, 0);
          end else begin
            tok = exp_q.pop_front();
            chk("out_din", 32'(out_din), 32'(tok));
            chk("iter_count_pre", iter_count, exp_cnt);
            chk("iter_count_w_pre", 32'(w_iter_count), exp_cnt & 3);
            if (gap_chk && last_wr >= 0)
              chk("write_gap", cyc - last_wr, 3);
            exp_cnt++;
          end
          last_wr = cyc;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int r0, w0, n;
    repeat (3) tick();
    @(negedge ap_clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_iter", iter_count, 0);
    chk("rst_out_din", 32'(out_din), 0);
    in_force = 1'b0;
    tick();
    ap_rst  = 1'b0;
    exp_cnt = 0;

    // Single token, ready at +2 and done at +5.
    rdy_dly = 2; done_dly = 5;
    r0 = rd_cnt; w0 = wr_cnt;
    push_in(1'b1, 1'b1);
    wait_idle(60);
    chk("t1_iter", iter_count, 1);
    chk("t1_reads", rd_cnt - r0, 1);
    chk("t1_writes", wr_cnt - w0, 1);

    // Back-to-back, ready and done in the start cycle.
    rdy_dly = 0; done_dly = 0;
    gap_chk = 1'b1; last_wr = -1;
    w0 = wr_cnt;
    push_in(1'b1, 1'b1);
    push_in(1'b0, 1'b1);
    push_in(1'b1, 1'b1);
    push_in(1'b1, 1'b1);
    wait_idle(60);
    gap_chk = 1'b0;
    chk("t2_iter", iter_count, 5);
    chk("t2_writes", wr_cnt - w0, 4);

    // Backpressure held in DONE for six cycles.
    rdy_dly = 0; done_dly = 2;
    out_full_n   = 1'b0;
    pe_done_seen = 1'b0;
    push_in(1'b1, 1'b1);
    push_in(1'b0, 1'b1);
    n = 0;
    while (!pe_done_seen && n < 50) begin
      tick();
      n++;
    end
    chk("bp_done_timeout", 32'(n >= 50), 0);
    tick();
    repeat (6) begin
      @(negedge ap_clk);
      chk("bp_write", 32'(out_write), 0);
      chk("bp_read", 32'(in_read), 0);
      chk("bp_busy", 32'(busy), 1);
      tick();
    end
    out_full_n = 1'b1;
    @(negedge ap_clk);
    chk("bp_release_write", 32'(out_write), 1);
    tick();
    @(negedge ap_clk);
    chk("bp_idle_read", 32'(in_read), 1);
    wait_idle(60);
    chk("t3_iter", iter_count, 7);

    // Reset while the PE is running.
    rdy_dly = 1; done_dly = 8;
    push_in(1'b1, 1'b0);
    repeat (5) tick();
    @(negedge ap_clk);
    chk("run_start_low", 32'(pe_ap_start), 0);
    chk("run_busy", 32'(busy), 1);
    #1;
    push_in(1'b0, 1'b1);
    ap_rst  = 1'b1;
    exp_cnt = 0;
    tick();
    ap_rst = 1'b0;
    @(negedge ap_clk);
    chk("post_rst_iter", iter_count, 0);
    chk("post_rst_busy", 32'(busy), 0);
    chk("post_rst_read", 32'(in_read), 1);
    wait_idle(80);
    chk("t4_iter", iter_count, 1);

    // Counter wrap on the 2-bit instance.
    tick();
    ap_rst  = 1'b1;
    exp_cnt = 0;
    tick();
    ap_rst  = 1'b0;
    rdy_dly = 0; done_dly = 0;
    push_in(1'b1, 1'b1);
    push_in(1'b0, 1'b1);
    push_in(1'b0, 1'b1);
    push_in(1'b1, 1'b1);
    push_in(1'b1, 1'b1);
    wait_idle(60);
    chk("wrap_narrow", 32'(w_iter_count), 1);
    chk("wrap_wide", iter_count, 5);

    // Spurious done while idle.
    spur_req = 1'b1;
    repeat (4) begin
      @(negedge ap_clk);
      chk("spur_busy", 32'(busy), 0);
      chk("spur_write", 32'(out_write), 0);
      tick();
    end
    chk("spur_iter", iter_count, 5);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
